edge_train_generator: RTL and testbench

Transmit side of the level-change signalling used across the lab designs. On a start request it produces a programmed number of transitions on a single output line, alternating rising and falling. The downstream both-edge detector turns each transition into one single-cycle pulse. High and low hold times are set by parameters, so the receiver sees evenly spaced events. The block also reports busy and done status to its controlling FSM.

---
 rtl/edge_train_generator.sv | 96 +++++++++
 tb/tb_edge_train_generator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_train_generator.sv
// Emits n_bordas alternating transitions on sinal with fixed high/low hold times; first transition on the accepting edge.
// No backpressure: iniciar is taken only when idle and dropped otherwise; abortar freezes sinal and returns to idle.
module edge_train_generator #(
    parameter int HIGH_W = 4,
    parameter int LOW_W  = 4,
    parameter int N_W    = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           iniciar,
    input  logic           abortar,
    input  logic [N_W-1:0] n_bordas,
    output logic           sinal,
    output logic           ocupado,
    output logic           pronto,
    output logic [N_W-1:0] restante
);

    localparam int MAX_W = (HIGH_W > LOW_W) ? HIGH_W : LOW_W;
    localparam int TW    = $clog2(MAX_W) + 1;
    localparam logic [TW-1:0] HIGH_END = TW'(HIGH_W - 1);
    localparam logic [TW-1:0] LOW_END  = TW'(LOW_W - 1);

    typedef enum logic [1:0] {OCIOSO, ESPERA, FIM} state_t;

    state_t         state_q, state_d;
    logic           sinal_q, sinal_d;
    logic [N_W-1:0] restante_q, restante_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [TW-1:0]  hold_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= OCIOSO;
            sinal_q    <= 1'b0;
            restante_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            sinal_q    <= sinal_d;
            restante_q <= restante_d;
            timer_q    <= timer_d;
        end
    end

    // Hold length follows the level just entered.
    assign hold_end = sinal_q ? HIGH_END : LOW_END;

    always_comb begin
        state_d    = state_q;
        sinal_d    = sinal_q;
        restante_d = restante_q;
        timer_d    = timer_q;
        if (abortar) begin
            state_d    = OCIOSO;
            timer_d    = '0;
            restante_d = '0;
        end else begin
            case (state_q)
                OCIOSO: begin
                    if (iniciar) begin
                        if (n_bordas != '0) begin
                            sinal_d    = ~sinal_q;
                            restante_d = n_bordas - 1'b1;
                            timer_d    = '0;
                            state_d    = ESPERA;
                        end else begin
                            state_d = FIM;
                        end
                    end
                end
                ESPERA: begin
                    if (timer_q == hold_end) begin
                        timer_d = '0;
                        if (restante_q != '0) begin
                            sinal_d    = ~sinal_q;
                            restante_d = restante_q - 1'b1;
                        end else begin
                            state_d = FIM;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                FIM:     state_d = OCIOSO;
                default: state_d = OCIOSO;
            endcase
        end
    end

    assign sinal    = sinal_q;
    assign restante = restante_q;
    assign ocupado  = (state_q == ESPERA);
    assign pronto   = (state_q == FIM);

endmodule

// File: tb/tb_edge_train_generator.sv
// Bench for edge_train_generator: two instances (4/4 and 2/3 hold times) against a transition-schedule model.
module tb_edge_train_generator;

    localparam int HI [2] = '{4, 2};
    localparam int LO [2] = '{4, 3};

    typedef logic [16:0][31:0] sched_t;

    logic       clock, reset;
    logic       ini [2];
    logic       ab  [2];
    logic [3:0] nb  [2];
    logic       sig [2];
    logic       oc  [2];
    logic       pr  [2];
    logic [3:0] rs  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    edge_train_generator #(.HIGH_W(4), .LOW_W(4), .N_W(4)) u_a (
        .clock(clock), .reset(reset), .iniciar(ini[0]), .abortar(ab[0]), .n_bordas(nb[0]),
        .sinal(sig[0]), .ocupado(oc[0]), .pronto(pr[0]), .restante(rs[0]));

    edge_train_generator #(.HIGH_W(2), .LOW_W(3), .N_W(4)) u_b (
        .clock(clock), .reset(reset), .iniciar(ini[1]), .abortar(ab[1]), .n_bordas(nb[1]),
        .sinal(sig[1]), .ocupado(oc[1]), .pronto(pr[1]), .restante(rs[1]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Model: a train is a list of absolute transition cycles plus the cycle pronto shows.
    logic   mrv [2];
    logic   mb  [2];
    logic   ml  [2];
    int     mn  [2];
    sched_t ms  [2];

    function automatic sched_t sched(logic b, int n, int k, int hi, int lo);
        sched_t s = '0;
        int     t = k;
        logic   l = b;
        for (int i = 0; i < n; i++) begin
            s[i] = t;
            l    = ~l;
            t    = t + (l ? hi : lo);
        end
        s[16] = t;
        return s;
    endfunction

    function automatic int cnt_at(int j, int c);
        int n_ = 0;
        for (int i = 0; i < mn[j]; i++)
            if (int'(ms[j][i]) <= c) n_++;
        return n_;
    endfunction

    function automatic int end_of(int j);
        return int'(ms[j][16]);
    endfunction

    function automatic logic exp_sig(int j, int c);
        if (!mrv[j]) return ml[j];
        return mb[j] ^ ((cnt_at(j, c) % 2) == 1);
    endfunction

    function automatic int exp_rs(int j, int c);
        if (!mrv[j] || c > end_of(j)) return 0;
        return mn[j] - cnt_at(j, c);
    endfunction

    function automatic logic exp_oc(int j, int c);
        return mrv[j] && (c < end_of(j));
    endfunction

    function automatic logic exp_pr(int j, int c);
        return mrv[j] && (c == end_of(j));
    endfunction

    function automatic logic idle_lvl(int j);
        return mrv[j] ? (mb[j] ^ ((mn[j] % 2) == 1)) : ml[j];
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                mrv[j] <= 1'b0;
                ml[j]  <= 1'b0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (ab[j]) begin
                    if (mrv[j] && cyc <= end_of(j)) begin
                        ml[j]  <= exp_sig(j, cyc);
                        mrv[j] <= 1'b0;
                    end
                end else if (ini[j] && !(mrv[j] && cyc <= end_of(j))) begin
                    mrv[j] <= 1'b1;
                    mb[j]  <= idle_lvl(j);
                    mn[j]  <= int'(nb[j]);
                    ms[j]  <= sched(idle_lvl(j), int'(nb[j]), cyc + 1, HI[j], LO[j]);
                end
            end
        end
    end

    task automatic chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", nm, cyc, act, expv);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("model_sinal[%0d]", j), int'(sig[j]), int'(exp_sig(j, cyc)));
                chk($sformatf("model_ocupado[%0d]", j), int'(oc[j]), int'(exp_oc(j, cyc)));
                chk($sformatf("model_pronto[%0d]", j), int'(pr[j]), int'(exp_pr(j, cyc)));
                chk($sformatf("model_restante[%0d]", j), int'(rs[j]), exp_rs(j, cyc));
            end
        end
    end

    // Loopback both-edge detector on instance b.
    logic prv_b;
    logic lb_en = 1'b0;
    int   pulses[$];
    always @(posedge clock) prv_b <= sig[1];
    always @(negedge clock) if (lb_en && !reset && sig[1] != prv_b) pulses.push_back(cyc);

    task automatic go_to(int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic start(int j, int n, output int k);
        @(negedge clock);
        ini[j] = 1'b1;
        nb[j]  = 4'(n);
        @(posedge clock);
        #1 k = cyc;
        @(negedge clock);
        ini[j] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1;
        for (int j = 0; j < 2; j++) begin
            ini[j] = 1'b0;
            ab[j]  = 1'b0;
            nb[j]  = 4'd0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_sinal", int'(sig[0]), 0);
        chk("reset_ocupado", int'(oc[0]), 0);
        chk("reset_pronto", int'(pr[0]), 0);
        chk("reset_restante", int'(rs[0]), 0);

        // n=3, 4/4 holds
        start(0, 3, k);
        chk("t1_rise_k", int'(sig[0]), 1);
        chk("t1_rest_k", int'(rs[0]), 2);
        go_to(k + 3);  chk("t1_hold_k3", int'(sig[0]), 1);
        go_to(k + 4);  chk("t1_fall_k4", int'(sig[0]), 0); chk("t1_rest_k4", int'(rs[0]), 1);
        go_to(k + 8);  chk("t1_rise_k8", int'(sig[0]), 1); chk("t1_rest_k8", int'(rs[0]), 0);
        go_to(k + 11); chk("t1_busy_k11", int'(oc[0]), 1); chk("t1_nodone_k11", int'(pr[0]), 0);
        go_to(k + 12); chk("t1_idle_k12", int'(oc[0]), 0); chk("t1_done_k12", int'(pr[0]), 1);
        go_to(k + 13); chk("t1_done_once", int'(pr[0]), 0); chk("t1_final", int'(sig[0]), 1);

        // loopback n=5 with 2/3 holds
        lb_en = 1'b1;
        start(1, 5, k);
        go_to(k + 14);
        lb_en = 1'b0;
        chk("lb_pulse_count", pulses.size(), 5);
        if (pulses.size() == 5) begin
            chk("lb_first_at_k", pulses[0], k);
            chk("lb_gap1", pulses[1] - pulses[0], 2);
            chk("lb_gap2", pulses[2] - pulses[1], 3);
            chk("lb_gap3", pulses[3] - pulses[2], 2);
            chk("lb_gap4", pulses[4] - pulses[3], 3);
        end
        chk("lb_final", int'(sig[1]), 1);

        // n=2 from level 1
        start(1, 2, k);
        chk("t3_fall_k", int'(sig[1]), 0);
        go_to(k + 3); chk("t3_rise_k3", int'(sig[1]), 1);
        go_to(k + 5); chk("t3_done", int'(pr[1]), 1);
        go_to(k + 6); chk("t3_final", int'(sig[1]), 1);

        // abort and start together: abort wins
        ini[1] = 1'b1; ab[1] = 1'b1; nb[1] = 4'd3;
        @(negedge clock);
        ini[1] = 1'b0; ab[1] = 1'b0;
        chk("abini_idle", int'(oc[1]), 0);
        chk("abini_sinal", int'(sig[1]), 1);

        // n=0
        start(0, 0, k);
        chk("n0_pronto", int'(pr[0]), 1);
        chk("n0_ocupado", int'(oc[0]), 0);
        chk("n0_sinal", int'(sig[0]), 1);
        go_to(k + 1); chk("n0_pronto_once", int'(pr[0]), 0);

        // n=6 from 1: iniciar while busy ignored, abort at k+5
        start(0, 6, k);
        chk("ab_fall_k", int'(sig[0]), 0);
        go_to(k + 1); ini[0] = 1'b1; nb[0] = 4'd2;
        go_to(k + 2); ini[0] = 1'b0;
        chk("ab_ign_rest", int'(rs[0]), 5);
        go_to(k + 4); chk("ab_rise_k4", int'(sig[0]), 1); chk("ab_rest_k4", int'(rs[0]), 4);
        ab[0] = 1'b1;
        go_to(k + 5); ab[0] = 1'b0;
        chk("ab_idle", int'(oc[0]), 0);
        chk("ab_frozen", int'(sig[0]), 1);
        chk("ab_rest0", int'(rs[0]), 0);
        chk("ab_nopronto", int'(pr[0]), 0);
        go_to(k + 9); chk("ab_nopronto_late", int'(pr[0]), 0);

        // async reset mid-hold, then n=1
        start(0, 3, k);
        go_to(k + 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_sinal", int'(sig[0]), 0);
        chk("arst_ocupado", int'(oc[0]), 0);
        chk("arst_pronto", int'(pr[0]), 0);
        chk("arst_restante", int'(rs[0]), 0);
        #1 reset = 1'b0;
        start(0, 1, k);
        chk("n1_rise_k", int'(sig[0]), 1);
        chk("n1_busy_k", int'(oc[0]), 1);
        go_to(k + 4); chk("n1_done", int'(pr[0]), 1); chk("n1_idle", int'(oc[0]), 0);
        go_to(k + 5); chk("n1_final", int'(sig[0]), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
